// File: rtl/mul_pkg.sv
// Shared types and constants for the iterative RV32M multiplier.
// Latency: none (declarations only).
// Backpressure: none.
package mul_pkg;
    localparam int MUL_XLEN  = 32;
    localparam int MUL_CNT_W = 6;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
endpackage

// File: rtl/mul_sign_ctl.sv
// Operand magnitudes, product sign and high-half select from funct3.
// Latency: combinational.
// Backpressure: none.
module mul_sign_ctl
    import mul_pkg::*;
#(
    parameter int XLEN = MUL_XLEN
) (
    input  logic [2:0]      i_funct3,
    input  logic [XLEN-1:0] i_srca,
    input  logic [XLEN-1:0] i_srcb,
    output logic [XLEN-1:0] o_mag_a,
    output logic [XLEN-1:0] o_mag_b,
    output logic            o_neg,
    output logic            o_sel_hi
);
    logic w_a_signed;
    logic w_b_signed;
    logic w_a_neg;
    logic w_b_neg;

    // Unknown codes fall through to MUL: both signed, low half.
    always_comb begin
        w_a_signed = 1'b1;
        w_b_signed = 1'b1;
        o_sel_hi   = 1'b0;
        case (i_funct3)
            F3_MULH:   o_sel_hi = 1'b1;
            F3_MULHSU: begin
                w_b_signed = 1'b0;
                o_sel_hi   = 1'b1;
            end
            F3_MULHU:  begin
                w_a_signed = 1'b0;
                w_b_signed = 1'b0;
                o_sel_hi   = 1'b1;
            end
            default: ;
        endcase
    end

    assign w_a_neg = w_a_signed & i_srca[XLEN-1];
    assign w_b_neg = w_b_signed & i_srcb[XLEN-1];
    assign o_mag_a = w_a_neg ? (~i_srca + 1'b1) : i_srca;
    assign o_mag_b = w_b_neg ? (~i_srcb + 1'b1) : i_srcb;
    assign o_neg   = w_a_neg ^ w_b_neg;
endmodule

// File: rtl/mul_unit.sv
// Iterative shift-add RV32M multiplier (MUL/MULH/MULHSU/MULHU); MUL_EARLY_EXIT_EN enables early exit.
// Latency: XLEN+2 cycles request-to-done (early exit: highest set bit of |b| + 3).
// Backpressure: stall holds the pipeline from request through RUN; start ignored outside IDLE.
module mul_unit
    import mul_pkg::*;
#(
    parameter int XLEN  = MUL_XLEN,
    parameter int CNT_W = MUL_CNT_W
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start_mul,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] srca,
    input  logic [XLEN-1:0] srcb,
    output logic            busy,
    output logic            stall,
    output logic            done,
    output logic [XLEN-1:0] result
);
    state_t              r_state;
    state_t              w_state_nxt;
    logic [2*XLEN-1:0]   r_acc;
    logic [CNT_W-1:0]    r_cnt;
    logic [XLEN-1:0]     r_mag_a;
    logic                r_neg;
    logic                r_sel_hi;
    logic [XLEN-1:0]     r_result;

    logic [XLEN-1:0]     w_mag_a;
    logic [XLEN-1:0]     w_mag_b;
    logic                w_neg;
    logic                w_sel_hi;
    logic                w_accept;
    logic [XLEN:0]       w_sum;
    logic [2*XLEN-1:0]   w_acc_sh1;
    logic [2*XLEN-1:0]   w_acc_nxt;
    logic [2*XLEN-1:0]   w_prod;
    logic                w_last;

    mul_sign_ctl #(.XLEN(XLEN)) u_sign_ctl (
        .i_funct3 (funct3),
        .i_srca   (srca),
        .i_srcb   (srcb),
        .o_mag_a  (w_mag_a),
        .o_mag_b  (w_mag_b),
        .o_neg    (w_neg),
        .o_sel_hi (w_sel_hi)
    );

    assign w_accept = (r_state == IDLE) && start_mul;

    // Add into the high half at XLEN+1 bits so the carry survives the shift.
    assign w_sum     = {1'b0, r_acc[2*XLEN-1:XLEN]} + (r_acc[0] ? {1'b0, r_mag_a} : '0);
    assign w_acc_sh1 = {w_sum, r_acc[XLEN-1:1]};

`ifdef MUL_EARLY_EXIT_EN
    logic [XLEN-2:0] w_rem_mask;
    logic            w_rem_zero;

    // Multiplier bits above the one consumed this cycle; once all zero, the
    // remaining iterations only shift, so collapse them into one alignment.
    assign w_rem_mask = {(XLEN-1){1'b1}} >> r_cnt;
    assign w_rem_zero = (r_acc[XLEN-1:1] & w_rem_mask) == '0;
    assign w_last     = w_rem_zero || (r_cnt == CNT_W'(XLEN-1));
    assign w_acc_nxt  = w_rem_zero ? (w_acc_sh1 >> (CNT_W'(XLEN-1) - r_cnt)) : w_acc_sh1;
`else
    assign w_last    = (r_cnt == CNT_W'(XLEN-1));
    assign w_acc_nxt = w_acc_sh1;
`endif

    assign w_prod = r_neg ? (~w_acc_nxt + 1'b1) : w_acc_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        busy        = 1'b0;
        stall       = 1'b0;
        done        = 1'b0;
        case (r_state)
            IDLE: begin
                stall = start_mul;
                if (start_mul) w_state_nxt = RUN;
            end
            RUN: begin
                busy  = 1'b1;
                stall = 1'b1;
                if (w_last) w_state_nxt = DONE;
            end
            DONE: begin
                busy        = 1'b1;
                done        = 1'b1;
                w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc    <= '0;
            r_cnt    <= '0;
            r_mag_a  <= '0;
            r_neg    <= 1'b0;
            r_sel_hi <= 1'b0;
            r_result <= '0;
        end else if (w_accept) begin
            r_acc    <= {{XLEN{1'b0}}, w_mag_b};
            r_cnt    <= '0;
            r_mag_a  <= w_mag_a;
            r_neg    <= w_neg;
            r_sel_hi <= w_sel_hi;
        end else if (r_state == RUN) begin
            r_acc <= w_acc_nxt;
            r_cnt <= r_cnt + CNT_W'(1);
            if (w_last) begin
                r_result <= r_sel_hi ? w_prod[2*XLEN-1:XLEN] : w_prod[XLEN-1:0];
            end
        end
    end

    assign result = r_result;
endmodule
